bias_accum_stage: RTL and testbench

Consumer end of the per-layer constant bias bus. Accepts `N_adder_tree` lanes of 18-bit signed partial sums from the adder trees over `N_GROUPS` consecutive beats and accumulates them per lane. On the final beat it adds the lane's 18-bit bias word from the bias bus, saturates the result to 18 bits, and presents one output vector under a valid/ready handshake. The block sits between the adder-tree outputs and the next layer's activation buffer.

---
 rtl/bias_accum_stage.sv | 117 +++++++++++
 tb/tb_bias_accum_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bias_accum_stage.sv
// Per-lane accumulation of N_GROUPS partial-sum beats plus bias, saturated to 18 bits (optional RELU via BIAS_ACCUM_RELU_EN).
// Latency: result registered on the edge accepting the last beat; one beat per cycle with no bubbles.
// Backpressure: in_ready drops only while a held result is not being drained by out_ready.
module bias_accum_stage #(
    parameter int N_adder_tree = 16,
    parameter int N_GROUPS     = 4,
    parameter int ACC_W        = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_adder_tree*18-1:0]   in_psum,
    input  logic [N_adder_tree*18-1:0]   bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_adder_tree*18-1:0]   out_data
);

    localparam int CNT_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_GROUPS - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(131071);
    localparam logic signed [ACC_W:0] SAT_MIN = -(ACC_W+1)'(131072);

    typedef enum logic {ACC, FULL} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              grp_cnt;
    logic                          accept;
    logic                          last_beat;
    logic                          first_beat;
    logic [N_adder_tree*18-1:0]    res_vec;

    assign out_valid  = (state_q == FULL);
    assign in_ready   = !(out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign first_beat = (grp_cnt == '0);
    assign last_beat  = accept && (grp_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt <= '0;
        end else if (accept) begin
            if (grp_cnt == LAST_CNT)
                grp_cnt <= '0;
            else
                grp_cnt <= grp_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ACC;
        else
            state_q <= state_d;
    end

    // A last beat always lands a new result, even while the old one drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:  if (last_beat) state_d = FULL;
            FULL: begin
                if (last_beat)
                    state_d = FULL;
                else if (out_ready)
                    state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic [17:0]             psum_l;
        logic [17:0]             bias_l;
        logic [ACC_W-1:0]        psum_ext;
        logic [ACC_W-1:0]        acc_q;
        logic [ACC_W-1:0]        acc_nxt;
        logic signed [ACC_W:0]   sum;
        logic [17:0]             sat;

        assign psum_l   = in_psum[18*i +: 18];
        assign bias_l   = bias[18*i +: 18];
        assign psum_ext = {{(ACC_W-18){psum_l[17]}}, psum_l};
        assign acc_nxt  = first_beat ? psum_ext : acc_q + psum_ext;
        assign sum      = {acc_nxt[ACC_W-1], acc_nxt} + {{(ACC_W+1-18){bias_l[17]}}, bias_l};

        always_comb begin
            sat = sum[17:0];
            if (sum > SAT_MAX)
                sat = 18'h1FFFF;
            else if (sum < SAT_MIN)
                sat = 18'h20000;
        end

`ifdef BIAS_ACCUM_RELU_EN
        assign res_vec[18*i +: 18] = sat[17] ? 18'd0 : sat;
`else
        assign res_vec[18*i +: 18] = sat;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                acc_q <= '0;
            else if (accept)
                acc_q <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_data <= '0;
        else if (last_beat)
            out_data <= res_vec;
    end

endmodule

// File: tb/tb_bias_accum_stage.sv
// Scoreboarded bench for bias_accum_stage: a default-parameter instance and an N_GROUPS=1 instance.
module tb_bias_accum_stage;
    localparam int N = 16;
    localparam int W = N * 18;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] bias;

    logic in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_psum, out_data;
    logic in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] in_psum1, out_data1;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] e0, e1, held;

    always #5 clk = ~clk;

    bias_accum_stage #(.N_adder_tree(N), .N_GROUPS(4), .ACC_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_psum(in_psum), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data));

    bias_accum_stage #(.N_adder_tree(N), .N_GROUPS(1), .ACC_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_psum(in_psum1), .bias(bias), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1));

    function automatic logic [W-1:0] pk(int l0, int l1, int rest);
        logic [W-1:0] v;
        logic [31:0] t;
        v = '0;
        for (int i = 0; i < N; i++) begin
            t = (i == 0) ? l0 : (i == 1) ? l1 : rest;
            v[18*i +: 18] = t[17:0];
        end
        return v;
    endfunction

    function automatic int rl(int v);
`ifdef BIAS_ACCUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int sat(int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic logic [W-1:0] ex(int l0, int l1, int rest);
        return pk(rl(l0), rl(l1), rl(rest));
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [W-1:0] p);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_psum  = p;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout act=in_ready_low exp=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beat1(input logic [W-1:0] p);
        int t;
        t = 0;
        in_valid1 = 1'b1;
        in_psum1  = p;
        @(negedge clk);
        while (!in_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready1) begin
            checks++;
            failures++;
            $display("FAIL beat1_timeout act=in_ready_low exp=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out act=%h exp=none", out_data);
            end else begin
                e0 = q.pop_front();
                chk("out_data", out_data, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out1 act=%h exp=none", out_data1);
            end else begin
                e1 = q1.pop_front();
                chk("out_data1", out_data1, e1);
            end
        end
    end

    initial begin
        int ps[6];
        int wt;
        ps = '{1000, -2000, 50000, 131071, -131072, 7};
        bias = pk(-4236, 2212, 0);
        rst_n = 1'b0;
        in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_psum1 = '0; out_ready1 = 1'b1;
        #12;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // bias example
        beat(pk(100, 100, 100));
        beat(pk(200, 200, 200));
        beat(pk(300, 300, 300));
        chk("no_early_valid", W'(out_valid), W'(0));
        q.push_back(ex(-3236, 3212, 1000));
        beat(pk(400, 400, 400));
        chk("latency_valid", W'(out_valid), W'(1));

        // saturation both directions
        for (int k = 0; k < 3; k++) beat(pk(-131072, 131071, 0));
        q.push_back(ex(-131072, 131071, 0));
        beat(pk(-131072, 131071, 0));

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) beat(pk(10, 10, 10));
        held = ex(-4196, 2252, 40);
        q.push_back(held);
        in_valid = 1'b1;
        in_psum  = pk(7, 7, 7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_out_valid", W'(out_valid), W'(1));
            chk("stall_out_data", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) beat(pk(7, 7, 7));
        chk("drained_valid", W'(out_valid), W'(0));
        q.push_back(ex(-4208, 2240, 28));
        beat(pk(7, 7, 7));
        chk("resume_valid", W'(out_valid), W'(1));
        @(negedge clk);

        // reset mid-accumulation
        beat(pk(1000, 1000, 1000));
        beat(pk(1000, 1000, 1000));
        chk("pre_rst_queue", W'(q.size()), W'(0));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", out_data, '0);
        chk("async_rst_valid", W'(out_valid), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) beat(pk(10, 10, 10));
        q.push_back(ex(-4196, 2252, 40));
        beat(pk(10, 10, 10));

        // N_GROUPS=1 back-to-back with continuous drain
        for (int k = 0; k < 6; k++) begin
            q1.push_back(ex(sat(ps[k] - 4236), sat(ps[k] + 2212), ps[k]));
            beat1(pk(ps[k], ps[k], ps[k]));
            in_valid1 = (k < 5);
            chk("b2b_valid", W'(out_valid1), W'(1));
            chk("b2b_in_ready", W'(in_ready1), W'(1));
        end

        wt = 0;
        while ((q.size() != 0 || q1.size() != 0) && wt < 20) begin
            @(posedge clk);
            wt++;
        end
        chk("queue_empty", W'(q.size()), W'(0));
        chk("queue1_empty", W'(q1.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
